// File: rtl/btn_debounce.sv
// btn_debounce: button input stage between the raw board pins and the CPU.
// Each button passes through a two-flop synchronizer into the clk_25mhz domain.
// A per-bit counter then debounces it. Press and release events are latched
// until software clears them. Levels and events are read over a small register
// port.
//
// Optional feature: define BTN_IRQ_EN to add the irq_mask register (address 3)
// and a registered interrupt output. When BTN_IRQ_EN is not defined, irq is
// tied to 0 and address 3 reads 0.
//
// Ports:
//   clk_25mhz  in   1      sole clock
//   reset      in   1      synchronous, active-high reset
//   btn        in   WIDTH  raw asynchronous button pins, 1 = pressed
//   stable     out  WIDTH  debounced levels
//   addr       in   2      register select (0 stable, 1 press, 2 release, 3 irq_mask)
//   rd         in   1      read strobe; rdata loads on the same edge
//   wr         in   1      write strobe
//   wdata      in   32     write data
//   rdata      out  32     registered read data; holds its value when rd is 0
//   irq        out  1      interrupt request (only active with BTN_IRQ_EN)
module btn_debounce #(
  parameter int unsigned WIDTH           = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk_25mhz,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] stable,
  input  logic [1:0]       addr,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_STABLE  = 2'd0;
  localparam logic [1:0] ADDR_PRESS   = 2'd1;
  localparam logic [1:0] ADDR_RELEASE = 2'd2;
  localparam logic [1:0] ADDR_MASK    = 2'd3;

  logic [WIDTH-1:0]         s1;
  logic [WIDTH-1:0]         s2;
  logic [WIDTH-1:0][CW-1:0] cnt;
  logic [WIDTH-1:0][CW-1:0] cnt_n;
  logic [WIDTH-1:0]         stable_n;
  logic [WIDTH-1:0]         press_pend;
  logic [WIDTH-1:0]         release_pend;
  logic [WIDTH-1:0]         press_n;
  logic [WIDTH-1:0]         release_n;
  logic [WIDTH-1:0]         press_clr;
  logic [WIDTH-1:0]         release_clr;
  logic [31:0]              rd_val;

  // Only the low WIDTH bits of wdata are ever stored.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // Debounce: a bit toggles only after DEBOUNCE_CYCLES consecutive mismatches.
  // Any return to the stable value clears the counter.
  always_comb begin
    cnt_n    = cnt;
    stable_n = stable;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (s2[i] == stable[i]) begin
        cnt_n[i] = '0;
      end else if (cnt[i] != CNT_MAX) begin
        cnt_n[i] = cnt[i] + CW'(1);
      end else begin
        cnt_n[i]    = '0;
        stable_n[i] = ~stable[i];
      end
    end
  end

  // Event latches: a new edge event takes priority over a same-cycle W1C.
  always_comb begin
    press_clr   = '0;
    release_clr = '0;
    if (wr && (addr == ADDR_PRESS))   press_clr   = wdata[WIDTH-1:0];
    if (wr && (addr == ADDR_RELEASE)) release_clr = wdata[WIDTH-1:0];
    press_n   = (press_pend   & ~press_clr)   | (stable_n & ~stable);
    release_n = (release_pend & ~release_clr) | (~stable_n & stable);
  end

`ifdef BTN_IRQ_EN
  logic [WIDTH-1:0] irq_mask;

  // Read mux sees pre-write register values, so rd+wr returns old data.
  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_STABLE:  rd_val = 32'(stable);
      ADDR_PRESS:   rd_val = 32'(press_pend);
      ADDR_RELEASE: rd_val = 32'(release_pend);
      ADDR_MASK:    rd_val = 32'(irq_mask);
      default:      rd_val = '0;
    endcase
  end

  // Mask register and registered interrupt, one cycle behind the pending bit.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr && (addr == ADDR_MASK)) irq_mask <= wdata[WIDTH-1:0];
      irq <= |(press_pend & irq_mask);
    end
  end
`else
  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_STABLE:  rd_val = 32'(stable);
      ADDR_PRESS:   rd_val = 32'(press_pend);
      ADDR_RELEASE: rd_val = 32'(release_pend);
      default:      rd_val = '0;
    endcase
  end

  assign irq = 1'b0;
`endif

  // Synchronizer, debounce state, event latches and read data register.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      s1           <= '0;
      s2           <= '0;
      cnt          <= '0;
      stable       <= '0;
      press_pend   <= '0;
      release_pend <= '0;
      rdata        <= '0;
    end else begin
      s1           <= btn;
      s2           <= s1;
      cnt          <= cnt_n;
      stable       <= stable_n;
      press_pend   <= press_n;
      release_pend <= release_n;
      if (rd) rdata <= rd_val;
    end
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Button input stage between the board's raw `btn[6:0]` pins and the CPU. Synchronizes each button into the `clk_25mhz` domain and debounces it with a per-bit counter. Latches press and release events until software clears them, and exposes stable levels and events through a small register port on the CPU data bus. Replaces the direct `btn` wiring into `Top`.

## Interface
Parameters:
- `WIDTH`, 7, number of buttons.
- `DEBOUNCE_CYCLES`, 250000, consecutive cycles a changed input must hold before it is accepted (10 ms at 25 MHz). Must be ≥ 2. Counter width is `$clog2(DEBOUNCE_CYCLES)`.

Ports:
- `clk_25mhz`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `btn`  in  WIDTH  raw asynchronous button pins, 1 = pressed.
- `stable`  out  WIDTH  debounced levels.
- `addr`  in  2  register select.
- `rd`  in  1  read strobe.
- `wr`  in  1  write strobe.
- `wdata`  in  32  write data.
- `rdata`  out  32  registered read data.
- `irq`  out  1  interrupt request. Only functional with `BTN_IRQ_EN`.

## Operation
- Synchronizer: two flip-flops per bit, `s1 <= btn`, `s2 <= s1`.
- Debouncer, one counter per bit:
  - If `s2 == stable[i]`, the counter clears to 0.
  - Otherwise, if `cnt < DEBOUNCE_CYCLES-1`, the counter increments.
  - Otherwise (`cnt == DEBOUNCE_CYCLES-1`), `stable[i]` toggles and the counter clears on the same edge.
- Any glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `stable`.
- Event latches:
  - `press[i]` sets on the edge where `stable[i]` goes 0→1.
  - `release[i]` sets on the edge where `stable[i]` goes 1→0.
- Register map (unused upper bits read 0):
  - 0: `stable`. Read-only; writes are ignored.
  - 1: `press` pending. Write-1-to-clear.
  - 2: `release` pending. Write-1-to-clear.
  - 3: `irq_mask`. Read/write with `BTN_IRQ_EN`; otherwise reads 0 and writes are ignored.
- When a W1C write and a new set of the same bit fall on the same edge, the set wins and the bit stays 1.
- `rd` and `wr` asserted together: the write takes effect, and `rdata` returns the value from before the write.

## Timing
- Reset values: `s1`, `s2`, `stable`, all counters, `press`, `release`, `irq_mask`, `rdata`, and `irq` are all 0.
- Input-to-`stable` latency: with `btn` changed before edge E0 and held, `stable` changes on the (DEBOUNCE_CYCLES+2)-th rising edge counting E0 as the first.
  - 2 edges for synchronization.
  - DEBOUNCE_CYCLES edges for the count.
- `press`/`release` become visible on the same edge as `stable` changes.
- Read latency is 1 cycle.
  - `rd` sampled at edge N loads `rdata` at edge N, valid during cycle N+1.
  - `rdata` holds its value when `rd` is 0.
- Write takes effect at the edge where `wr` is sampled high.
- Reset mid-debounce: counters and `stable` clear. A button still held after reset deasserts is re-debounced from zero and produces a fresh `press`.
- Input back to the `stable` value mid-count: the counter clears on the next edge; there is no partial credit.

## Configuration
- `BTN_IRQ_EN` defined:
  - Adds `irq_mask` (register 3).
  - `irq` is registered: `irq <= |(press & irq_mask)`, so it asserts one cycle after the `press` bit sets.
  - `irq` stays high until the pending bit is cleared or masked.
- `BTN_IRQ_EN` undefined:
  - `irq` is tied to 0.
  - Register 3 reads 0 and no mask logic is synthesized.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- Reset, then hold `btn=7'b0000001` → `stable` = 0 for 5 edges, `stable=7'h01` on the 6th edge. A read of address 1 then returns `32'h1`.
- 3-cycle pulse on `btn[2]` → `stable`, `press`, and `release` all stay 0.
- Bounce `btn[3]` as 1,1,1,0,1,1,1,1 (one cycle each) → a single `press[3]` event, later than in scenario 1 because the counter restarts. Releasing yields `release[3]=1`.
- Write `32'h1` to address 1 on the same edge a new `press[0]` sets → `press[0]` stays 1. A following clear with no event → reads 0.
- Assert `reset` while `cnt` = 2 with `btn[1]` held, then deassert → `stable[1]` = 0, then rises 6 edges later with `press[1]=1`.
- With `BTN_IRQ_EN`: write `irq_mask=7'h10`, then press `btn[4]` → `irq` = 1 one cycle after `press[4]`. A press on `btn[0]` alone keeps `irq` = 0. Clearing address 1 bit 4 drops `irq` on the following edge.
